// File: rtl/benes_cfg_loader.sv
// benes_cfg_loader
//   Control stage in front of the Benes network. Stage configuration words
//   arrive on a valid/ready stream and land in a shadow bank. A per-stage
//   written-mask tracks frame completeness. When a complete frame is waiting
//   and the datapath grants apply_en, the whole shadow bank is copied into the
//   active switch_selection array on one edge.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cfg_valid/ready     config beat handshake
//   cfg_stage/bits/last target stage, switch settings (1 = crossed), frame end
//   cfg_flush           drop the shadow frame; active config kept
//   apply_en            downstream grant for a config swap
//   switch_selection    active per-stage switch settings (reset = identity)
//   cfg_pending         complete frame waiting for apply_en
//   cfg_applied         one-cycle pulse after a commit
//   err_range           one-cycle pulse: accepted beat addressed a missing stage
//   err_incomplete      one-cycle pulse: frame closed with stages missing
//   epoch               number of commits (wraps)
module benes_cfg_loader #(
  parameter int unsigned STAGE_NUM  = 5,
  parameter int unsigned SWITCH_NUM = 4,
  parameter int unsigned EPOCH_W    = 8,
  localparam int unsigned STAGE_W   = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [STAGE_W-1:0]    cfg_stage,
  input  logic [SWITCH_NUM-1:0] cfg_bits,
  input  logic                  cfg_last,
  input  logic                  cfg_flush,
  input  logic                  apply_en,
  output logic [SWITCH_NUM-1:0] switch_selection [0:STAGE_NUM-1],
  output logic                  cfg_pending,
  output logic                  cfg_applied,
  output logic                  err_range,
  output logic                  err_incomplete,
  output logic [EPOCH_W-1:0]    epoch
);

  typedef enum logic {
    LOAD    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [STAGE_NUM-1:0]    mask_q, mask_d;
  logic [SWITCH_NUM-1:0]   shadow_q [STAGE_NUM];
  logic [SWITCH_NUM-1:0]   shadow_d [STAGE_NUM];
  logic [SWITCH_NUM-1:0]   sel_q    [STAGE_NUM];
  logic [SWITCH_NUM-1:0]   sel_d    [STAGE_NUM];
  logic [EPOCH_W-1:0]      epoch_q, epoch_d;
  logic                    applied_q, applied_d;
  logic                    err_range_q, err_range_d;
  logic                    err_inc_q, err_inc_d;

  logic                    accept;
  logic [STAGE_NUM-1:0]    hit;
  logic [STAGE_NUM-1:0]    mask_after;

  // Ready is held low during reset so nothing is accepted while state is
  // being forced.
  assign cfg_ready = !rst && (state_q == LOAD) && !cfg_flush;
  assign accept    = cfg_valid && cfg_ready;

  // One-hot decode of the target stage; an out-of-range index decodes to
  // no bit at all, which is what leaves the mask and shadow untouched.
  always_comb begin
    hit = '0;
    for (int unsigned s = 0; s < STAGE_NUM; s++) begin
      if (32'(cfg_stage) == s) hit[s] = 1'b1;
    end
  end

  assign mask_after = mask_q | hit;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    shadow_d    = shadow_q;
    sel_d       = sel_q;
    epoch_d     = epoch_q;
    applied_d   = 1'b0;
    err_range_d = 1'b0;
    err_inc_d   = 1'b0;

    if (cfg_flush) begin
      // Flush wins over a simultaneous apply_en; no commit, no error.
      mask_d  = '0;
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            for (int unsigned s = 0; s < STAGE_NUM; s++) begin
              if (hit[s]) shadow_d[s] = cfg_bits;
            end
            mask_d      = mask_after;
            err_range_d = (hit == '0);
            if (cfg_last) begin
              if (&mask_after) begin
                state_d = PENDING;
              end else begin
                err_inc_d = 1'b1;
                mask_d    = '0;
              end
            end
          end
        end
        PENDING: begin
          if (apply_en) begin
            sel_d     = shadow_q;
            epoch_d   = epoch_q + EPOCH_W'(1);
            mask_d    = '0;
            state_d   = LOAD;
            applied_d = 1'b1;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      mask_q      <= '0;
      shadow_q    <= '{default: '0};
      sel_q       <= '{default: '0};
      epoch_q     <= '0;
      applied_q   <= 1'b0;
      err_range_q <= 1'b0;
      err_inc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      shadow_q    <= shadow_d;
      sel_q       <= sel_d;
      epoch_q     <= epoch_d;
      applied_q   <= applied_d;
      err_range_q <= err_range_d;
      err_inc_q   <= err_inc_d;
    end
  end

  assign switch_selection = sel_q;
  assign cfg_pending      = (state_q == PENDING);
  assign cfg_applied      = applied_q;
  assign err_range        = err_range_q;
  assign err_incomplete   = err_inc_q;
  assign epoch            = epoch_q;

endmodule

// File: doc/benes_cfg_loader.md
Name: benes_cfg_loader

Overview:
- Upstream control stage of the Benes interconnect. It builds and drives the per-stage switch-selection array (`switch_selection`) that the benes network consumes.
- Accepts stage configuration words over a valid/ready stream into a shadow bank, then checks that the frame is complete.
- Commits the whole bank atomically, on a single edge, when the downstream datapath grants `apply_en`. The network therefore never sees a half-updated permutation.

Parameters:
- STAGE_NUM, 5: number of Benes stages (2*log2(SIZE)-1, SIZE=8).
- SWITCH_NUM, 4: 2x2 switches per stage (SIZE/2). Bit=1 means crossed, 0 means straight.
- EPOCH_W, 8: width of the committed-configuration counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  loader can accept a beat.
- cfg_stage  in  $clog2(STAGE_NUM)  target stage index of the beat.
- cfg_bits  in  SWITCH_NUM  switch settings for that stage.
- cfg_last  in  1  beat closes the frame.
- cfg_flush  in  1  discard the shadow frame; active config is untouched.
- apply_en  in  1  downstream grant, high when a config swap is safe.
- switch_selection  out  [SWITCH_NUM-1:0] x [0:STAGE_NUM-1]  active config to the network.
- cfg_pending  out  1  complete frame waiting for apply_en.
- cfg_applied  out  1  one-cycle pulse after a commit.
- err_range  out  1  one-cycle pulse: beat had cfg_stage >= STAGE_NUM.
- err_incomplete  out  1  one-cycle pulse: cfg_last arrived with a stage missing.
- epoch  out  EPOCH_W  count of commits.

Behaviour:
- Reset (async assert, released synchronously by clk):
  - switch_selection all 0, which is the identity permutation.
  - Shadow bank = 0, written-mask = 0.
  - cfg_pending, cfg_applied, err_range, err_incomplete = 0; epoch = 0; state = LOAD.
  - cfg_ready = 0 while rst is high.
- Reset mid-frame or while PENDING: the shadow frame is lost and active config returns to identity.
- States: LOAD, PENDING.
- Handshake: a beat is accepted only on the edge where cfg_valid & cfg_ready. Once cfg_valid is asserted, the source holds stage/bits/last stable until accepted.
- cfg_ready = 1 only in LOAD with cfg_flush = 0.
- LOAD, accepted beat with cfg_stage < STAGE_NUM:
  - shadow[cfg_stage] <= cfg_bits; mask[cfg_stage] <= 1.
  - Rewriting a stage is allowed; the last write wins.
- LOAD, accepted beat with cfg_stage >= STAGE_NUM:
  - Data is dropped and the mask is unchanged.
  - err_range pulses on the next cycle.
  - If cfg_last is also set, the frame check below still runs on the unchanged mask.
- LOAD, accepted beat with cfg_last = 1, checked against the mask including this beat:
  - All STAGE_NUM bits set: go to PENDING; cfg_pending = 1 from the next cycle.
  - Otherwise: err_incomplete pulses next cycle, mask clears, stay in LOAD. The shadow data is kept but becomes unreachable without rewriting all stages.
- PENDING:
  - cfg_ready = 0.
  - On the first edge with apply_en = 1: switch_selection <= shadow (all stages on the same edge), epoch <= epoch+1 (wraps 2^EPOCH_W-1 -> 0), mask clears, state -> LOAD.
  - cfg_pending falls and cfg_applied pulses for exactly one cycle following that edge.
  - Latency: apply_en high at edge N gives new switch_selection visible after edge N.
- apply_en in LOAD is ignored, and switch_selection never changes there.
- cfg_flush = 1 at an edge, any state: mask clears, state -> LOAD, cfg_pending -> 0; no commit and no error.
  - Flush beats a simultaneous apply_en.
  - A beat presented alongside flush is not accepted, because ready is low.
- Error pulses and cfg_applied are registered; they never assert in the same cycle as the triggering edge's inputs.

Test Plan:
- Reset then idle -> switch_selection all 4'h0, epoch=0, cfg_ready=1 one cycle after rst falls.
- Beats stage0..4 = 4'h1,4'h2,4'h4,4'h8,4'hF (last on stage4), apply_en held 0 for 10 cycles -> cfg_pending=1, outputs unchanged. Then apply_en=1 for one cycle -> next cycle switch_selection={1,2,4,8,F}, cfg_applied single pulse, epoch=1.
- Frame of stages 0,1,3,4 with last -> err_incomplete one pulse, no PENDING. Then a full frame commits correctly.
- Beat with cfg_stage=6 mid-frame -> err_range pulse, shadow unchanged, subsequent full frame commits.
- Stage2 written 4'h3 then 4'h5 within one frame -> committed stage2 = 4'h5.
- In PENDING assert cfg_flush and apply_en on the same edge -> no commit, epoch unchanged, back to LOAD.
- 256 commits -> epoch wraps 255 -> 0.
- Assert rst asynchronously mid-PENDING -> outputs zero immediately, no cfg_applied.
